debug_loader: RTL and testbench

Program loader for the core's instruction memory debug write port. It accepts a byte stream over a valid/ready handshake, decodes a framed program image (word count, payload, checksum), assembles little-endian 32-bit instructions and drives DEBUG_SIG/DEBUG_addr/DEBUG_instr/clk_debug into the frontend's instruction memory. DEBUG_SIG also serves as the core-hold indication while loading; it sits between the host byte source (UART receiver) and the frontend stage.

---
 rtl/debug_loader_pkg.sv | 30 +++
 rtl/debug_loader_byte_assembler.sv | 49 ++++
 rtl/debug_loader.sv | 146 ++++++++++++++
 tb/tb_debug_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_loader_pkg.sv
// Shared types and constants for the debug program loader: FSM states, frame
// geometry and the checksum width.
package debug_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;
   localparam int CHK_W      = 8;

   // States in which a byte may be consumed from the host stream.
   function automatic logic is_accepting(input state_e s);
      return s inside {ST_HDR, ST_DATA, ST_CHK};
   endfunction

   // States in which the core is held and the memory is in write mode.
   function automatic logic is_loading(input state_e s);
      return s inside {ST_HDR, ST_DATA, ST_WR_SETUP, ST_WR_PULSE, ST_CHK};
   endfunction

endpackage

// File: rtl/debug_loader_byte_assembler.sv
// Collects four bytes into a little-endian 32-bit word; word/word_valid present
// the completed word combinationally in the cycle the fourth byte arrives.
module debug_loader_byte_assembler
   import debug_loader_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] data_q, data_d;

   // NOTE: every variable gets a default first so no path through the block
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (clear) begin
         idx_d  = '0;
         data_d = '0;
      end else if (byte_en) begin
         idx_d  = idx_q + 2'd1;
         data_d = {byte_in, data_q[23:8]};
      end
   end

   assign word       = {byte_in, data_q};
   assign word_valid = byte_en && !clear && (idx_q == LAST_IDX);

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/debug_loader.sv
// Framed program-image loader: parses count/payload/checksum from a byte stream
// and drives the frontend instruction-memory debug write port.
module debug_loader
   import debug_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'd0
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        DEBUG_SIG,
   output logic [31:0] DEBUG_addr,
   output logic [31:0] DEBUG_instr,
   output logic        clk_debug,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] words_loaded
);

   state_e             state_q, state_d;
   logic [31:0]        n_q, n_d;
   logic [CHK_W-1:0]   chk_q, chk_d;
   logic [31:0]        words_q, words_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        instr_q, instr_d;
   logic               rx_ready_q, rx_ready_d;
   logic               sig_q, sig_d;
   logic               clk_dbg_q, clk_dbg_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               start_ok;
   logic               accept;
   logic [31:0]        asm_word;
   logic               asm_valid;

   assign start_ok = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
   assign accept   = rx_valid && rx_ready_q;

   // Header count and payload words share one assembler; its index wraps to
   // zero after the header, so payload parsing starts aligned.
   debug_loader_byte_assembler u_asm (
      .clk        (clk),
      .nrst       (nrst),
      .clear      (start_ok),
      .byte_en    (accept && (state_q inside {ST_HDR, ST_DATA})),
      .byte_in    (rx_data),
      .word       (asm_word),
      .word_valid (asm_valid)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start_ok) state_d = ST_HDR;
         ST_HDR: begin
            if (asm_valid) begin
               if (asm_word > MAX_WORDS) state_d = ST_ERR;
               else if (asm_word == '0)  state_d = ST_CHK;
               else                      state_d = ST_DATA;
            end
         end
         ST_DATA:     if (asm_valid) state_d = ST_WR_SETUP;
         ST_WR_SETUP: state_d = ST_WR_PULSE;
         ST_WR_PULSE: state_d = (words_q == n_q) ? ST_CHK : ST_DATA;
         ST_CHK:      if (accept) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the next state so that every port is a flop.
   always_comb begin
      n_d        = n_q;
      chk_d      = chk_q;
      words_d    = words_q;
      addr_d     = addr_q;
      instr_d    = instr_q;
      done_d     = done_q;
      err_d      = err_q;
      if (start_ok) begin
         n_d     = '0;
         chk_d   = '0;
         words_d = '0;
         addr_d  = BASE_ADDR;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
      if (state_q == ST_HDR && asm_valid)  n_d = asm_word;
      if (state_q == ST_DATA && accept)    chk_d = chk_q ^ rx_data;
      if (state_q == ST_DATA && asm_valid) instr_d = asm_word;
      if (state_q == ST_WR_SETUP)          words_d = words_q + 32'd1;
      if (state_q == ST_WR_PULSE)          addr_d = addr_q + 32'd1;
      if (state_q == ST_CHK && state_d == ST_DONE) done_d = 1'b1;
      if (state_q != ST_ERR && state_d == ST_ERR)  err_d  = 1'b1;
      rx_ready_d = is_accepting(state_d);
      sig_d      = is_loading(state_d);
      clk_dbg_d  = (state_d == ST_WR_PULSE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         n_q        <= '0;
         chk_q      <= '0;
         words_q    <= '0;
         addr_q     <= '0;
         instr_q    <= '0;
         rx_ready_q <= 1'b0;
         sig_q      <= 1'b0;
         clk_dbg_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         n_q        <= n_d;
         chk_q      <= chk_d;
         words_q    <= words_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         rx_ready_q <= rx_ready_d;
         sig_q      <= sig_d;
         clk_dbg_q  <= clk_dbg_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign rx_ready     = rx_ready_q;
   assign DEBUG_SIG    = sig_q;
   assign busy         = sig_q;
   assign DEBUG_addr   = addr_q;
   assign DEBUG_instr  = instr_q;
   assign clk_debug    = clk_dbg_q;
   assign done         = done_q;
   assign error        = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: frames with hand-computed checksums, a write
// monitor on clk_debug, and per-scenario inline comparisons.
module tb_debug_loader;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        DEBUG_SIG;
   logic [31:0] DEBUG_addr;
   logic [31:0] DEBUG_instr;
   logic        clk_debug;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] words_loaded;

   debug_loader dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .DEBUG_SIG    (DEBUG_SIG),
      .DEBUG_addr   (DEBUG_addr),
      .DEBUG_instr  (DEBUG_instr),
      .clk_debug    (clk_debug),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0    = 0;

   always @(posedge clk) cyc++;

   // Write monitor: logs every strobe and flags handshake/stability problems.
   logic [31:0] wr_addr[$];
   logic [31:0] wr_instr[$];
   int          rdy_viol = 0, stab_viol = 0, long_pulse = 0;
   logic        prev_rdy = 1'b0, prev_pulse = 1'b0;
   logic [31:0] prev_addr = '0, prev_instr = '0;

   always @(negedge clk) begin
      if (clk_debug) begin
         wr_addr.push_back(DEBUG_addr);
         wr_instr.push_back(DEBUG_instr);
         if (rx_ready || prev_rdy) rdy_viol++;
         if (prev_addr !== DEBUG_addr || prev_instr !== DEBUG_instr) stab_viol++;
         if (prev_pulse) long_pulse++;
      end
      prev_rdy   = rx_ready;
      prev_pulse = clk_debug;
      prev_addr  = DEBUG_addr;
      prev_instr = DEBUG_instr;
   end

   logic [7:0] frame[$];

   task automatic push_word(input logic [31:0] w);
      frame.push_back(w[7:0]);
      frame.push_back(w[15:8]);
      frame.push_back(w[23:16]);
      frame.push_back(w[31:24]);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_instr.delete();
      rdy_viol   = 0;
      stab_viol  = 0;
      long_pulse = 0;
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b, input bit gappy);
      logic r;
      bit   got;
      if (gappy) begin
         rx_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      got      = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         r = rx_ready;
         @(negedge clk);
         got = r;
      end
      rx_valid = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL byte_accept: byte %h not taken within 64 cycles", b);
      end
   endtask

   task automatic send_frame(input bit gappy);
      for (int i = 0; i < frame.size(); i++) send_byte(frame[i], gappy);
   endtask

   task automatic do_start();
      start = 1'b1;
      t0    = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(output int elapsed);
      for (int i = 0; i < 300 && !(done || error); i++) @(negedge clk);
      elapsed = cyc - t0;
      if (!(done || error)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL end_timeout: done/error not seen within 300 cycles");
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
      #12;
      n_cmp++;
      if ({rx_ready, DEBUG_SIG, clk_debug, busy, done, error, DEBUG_addr, DEBUG_instr, words_loaded} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: rdy=%b sig=%b clkd=%b busy=%b done=%b err=%b addr=%h instr=%h wl=%0d want all 0",
                  rx_ready, DEBUG_SIG, clk_debug, busy, done, error, DEBUG_addr, DEBUG_instr, words_loaded);
      end
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rx_ready, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_after_reset: rdy=%b busy=%b want 0 0", rx_ready, busy);
      end
   endtask

   task automatic test_basic(input logic [7:0] cks, input bit good);
      int el;
      logic [31:0] exp_i[2] = '{32'h0000_0013, 32'h0010_0093};
      clear_log();
      frame.delete();
      push_word(32'd2); push_word(exp_i[0]); push_word(exp_i[1]);
      frame.push_back(cks);
      do_start();
      n_cmp++;
      if ({DEBUG_SIG, busy, rx_ready} !== 3'b111) begin
         n_bad++;
         $display("FAIL hdr_entry: sig=%b busy=%b rdy=%b want 1 1 1", DEBUG_SIG, busy, rx_ready);
      end
      send_frame(1'b0);
      wait_end(el);
      if (good) begin
         n_cmp++;
         if (el !== 18) begin
            n_bad++;
            $display("FAIL load_latency: got %0d cycles want 18", el);
         end
      end
      n_cmp++;
      if ({done, error} !== (good ? 2'b10 : 2'b01)) begin
         n_bad++;
         $display("FAIL status: done=%b err=%b want done=%b err=%b", done, error, good, !good);
      end
      n_cmp++;
      if ({DEBUG_SIG, busy, rx_ready} !== 3'b000) begin
         n_bad++;
         $display("FAIL end_idle: sig=%b busy=%b rdy=%b want 0 0 0", DEBUG_SIG, busy, rx_ready);
      end
      n_cmp++;
      if (words_loaded !== 32'd2) begin
         n_bad++;
         $display("FAIL words_loaded: got %0d want 2", words_loaded);
      end
      n_cmp++;
      if (wr_addr.size() !== 2) begin
         n_bad++;
         $display("FAIL write_count: got %0d want 2", wr_addr.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 32'(i) || wr_instr[i] !== exp_i[i]) begin
               n_bad++;
               $display("FAIL write_%0d: got addr %h instr %h want addr %h instr %h",
                        i, wr_addr[i], wr_instr[i], 32'(i), exp_i[i]);
            end
         end
      end
      n_cmp++;
      if (rdy_viol !== 0 || stab_viol !== 0 || long_pulse !== 0) begin
         n_bad++;
         $display("FAIL write_timing: rdy_viol=%0d stab_viol=%0d long_pulse=%0d want 0 0 0",
                  rdy_viol, stab_viol, long_pulse);
      end
   endtask

   task automatic test_oversize();
      clear_log();
      frame.delete();
      push_word(32'd1025);
      do_start();
      send_frame(1'b0);
      n_cmp++;
      if ({error, done, busy, rx_ready} !== 4'b1000) begin
         n_bad++;
         $display("FAIL oversize_err: err=%b done=%b busy=%b rdy=%b want 1 0 0 0", error, done, busy, rx_ready);
      end
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      n_cmp++;
      if (wr_addr.size() !== 0 || rx_ready !== 1'b0 || error !== 1'b1) begin
         n_bad++;
         $display("FAIL oversize_quiet: writes=%0d rdy=%b err=%b want 0 0 1", wr_addr.size(), rx_ready, error);
      end
   endtask

   task automatic test_max_count();
      frame.delete();
      push_word(32'd1024);
      do_start();
      send_frame(1'b0);
      n_cmp++;
      if ({error, busy, rx_ready} !== 3'b011) begin
         n_bad++;
         $display("FAIL max_count_accepted: err=%b busy=%b rdy=%b want 0 1 1", error, busy, rx_ready);
      end
      #2 nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero();
      int el;
      clear_log();
      frame.delete();
      push_word(32'd0);
      frame.push_back(8'h00);
      do_start();
      send_frame(1'b0);
      wait_end(el);
      n_cmp++;
      if ({done, error} !== 2'b10 || words_loaded !== 32'd0 || wr_addr.size() !== 0) begin
         n_bad++;
         $display("FAIL zero_frame: done=%b err=%b wl=%0d writes=%0d want 1 0 0 0",
                  done, error, words_loaded, wr_addr.size());
      end
      n_cmp++;
      if (el !== 6) begin
         n_bad++;
         $display("FAIL zero_latency: got %0d cycles want 6", el);
      end
   endtask

   task automatic test_back_to_back_gappy();
      int el;
      logic [31:0] exp_i[3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_A5A5};
      clear_log();
      frame.delete();
      push_word(32'd3);
      for (int i = 0; i < 3; i++) push_word(exp_i[i]);
      frame.push_back(8'h2A);
      do_start();
      send_frame(1'b1);
      wait_end(el);
      n_cmp++;
      if ({done, error} !== 2'b10 || words_loaded !== 32'd3) begin
         n_bad++;
         $display("FAIL gappy_status: done=%b err=%b wl=%0d want 1 0 3", done, error, words_loaded);
      end
      n_cmp++;
      if (wr_addr.size() !== 3) begin
         n_bad++;
         $display("FAIL gappy_count: got %0d want 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (wr_addr[i] !== 32'(i) || wr_instr[i] !== exp_i[i]) begin
               n_bad++;
               $display("FAIL gappy_write_%0d: got addr %h instr %h want addr %h instr %h",
                        i, wr_addr[i], wr_instr[i], 32'(i), exp_i[i]);
            end
         end
      end
      n_cmp++;
      if (rdy_viol !== 0 || stab_viol !== 0 || long_pulse !== 0) begin
         n_bad++;
         $display("FAIL gappy_timing: rdy_viol=%0d stab_viol=%0d long_pulse=%0d want 0 0 0",
                  rdy_viol, stab_viol, long_pulse);
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      frame.delete();
      push_word(32'd5);
      push_word(32'h1111_1111);
      push_word(32'h2222_2222);
      frame.push_back(8'h33);
      do_start();
      send_frame(1'b0);
      n_cmp++;
      if (wr_addr.size() !== 2 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_progress: writes=%0d busy=%b want 2 1", wr_addr.size(), busy);
      end
      #2 nrst = 1'b0;
      #1;
      n_cmp++;
      if ({rx_ready, DEBUG_SIG, clk_debug, busy, done, error, DEBUG_addr, DEBUG_instr, words_loaded} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset_values: rdy=%b sig=%b clkd=%b busy=%b done=%b err=%b addr=%h instr=%h wl=%0d want all 0",
                  rx_ready, DEBUG_SIG, clk_debug, busy, done, error, DEBUG_addr, DEBUG_instr, words_loaded);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic(8'h90, 1'b1);
      test_basic(8'h81, 1'b0);
      test_oversize();
      test_max_count();
      test_zero();
      test_back_to_back_gappy();
      test_reset_mid();
      test_basic(8'h90, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
